// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_gen processing element.
// Holds the FSM state encoding and the signed saturation limits for a DW-bit result.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/pe_gen_if.sv
// Operand/result bundle of a pe_gen tile.
// The slave side is the tile; the master side is whoever feeds it.
interface pe_gen_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic                 start;
    logic [CW-1:0]        max_cntr;
    logic                 acc_keep;
    logic signed [DW-1:0] a_in;
    logic                 awe;
    logic signed [DW-1:0] b_in;
    logic                 bwe;
    logic                 ais;
    logic                 bis;
    logic                 aff;
    logic                 bff;
    logic signed [DW-1:0] a_out;
    logic signed [DW-1:0] b_out;
    logic                 awe_next;
    logic                 bwe_next;
    logic                 start_next;
    logic                 se;
    logic                 fout;
    logic                 sat;
    logic signed [DW-1:0] s_out;

    modport master (
        output start, max_cntr, acc_keep, a_in, awe, b_in, bwe, ais, bis,
        input  aff, bff, a_out, b_out, awe_next, bwe_next, start_next, se, fout, sat, s_out
    );

    modport slave (
        input  start, max_cntr, acc_keep, a_in, awe, b_in, bwe, ais, bis,
        output aff, bff, a_out, b_out, awe_next, bwe_next, start_next, se, fout, sat, s_out
    );
endinterface

// File: rtl/pe_fifo.sv
// Small synchronous operand FIFO with a combinational head.
// A write while full is taken only if the head is popped in the same cycle.
module pe_fifo #(
    parameter int DW     = 16,
    parameter int FDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW   = $clog2(FDEPTH);
    localparam int CNTW = PW + 1;

    logic [DW-1:0]   mem_q [FDEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            wr_ok, rd_ok;

    assign full_o  = (count_q == CNTW'(FDEPTH));
    assign empty_o = (count_q == '0);
    assign rd_ok   = rd_i && !empty_o;
    assign wr_ok   = wr_i && (!full_o || rd_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; only pointers and count define validity, so the array maps to plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/pe_gen.sv
// Systolic MAC tile: pops A/B pairs from its FIFOs, accumulates, forwards them downstream,
// and returns a shifted, saturated dot product one cycle after the last pair.
module pe_gen #(
    parameter int DW     = 16,
    parameter int ACCW   = 40,
    parameter int FDEPTH = 4,
    parameter int CW     = 8,
    parameter int FRAC   = 0
) (
    input logic     clk,
    input logic     rst_n,
    pe_gen_if.slave bus
);
    import pe_pkg::*;

    localparam logic signed [ACCW-1:0] S_MAX = ACCW'(sat_max(DW));
    localparam logic signed [ACCW-1:0] S_MIN = ACCW'(sat_min(DW));

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic signed [DW-1:0]   a_out_q, a_out_d, b_out_q, b_out_d, s_out_q, s_out_d;
    logic                   fwd_q, fwd_d, fout_q, fout_d, sat_q, sat_d, start_next_q;
    logic signed [DW-1:0]   a_head, b_head;
    logic                   a_full, b_full, a_empty, b_empty, pop;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW:0]   sum;
    logic signed [ACCW-1:0] scaled;
    logic                   clip_hi, clip_lo;

    pe_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .wr_i(bus.awe), .wdata_i(bus.a_in), .rd_i(pop),
        .rdata_o(a_head), .full_o(a_full), .empty_o(a_empty)
    );

    pe_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .wr_i(bus.bwe), .wdata_i(bus.b_in), .rd_i(pop),
        .rdata_o(b_head), .full_o(b_full), .empty_o(b_empty)
    );

    // One guard bit above the accumulator exposes a signed wrap of the addition.
    assign prod    = (2*DW)'(a_head) * (2*DW)'(b_head);
    assign sum     = (ACCW+1)'(acc_q) + (ACCW+1)'(prod);
    assign scaled  = acc_q >>> FRAC;
    assign clip_hi = (scaled > S_MAX);
    assign clip_lo = (scaled < S_MIN);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        s_out_d = s_out_q;
        sat_d   = sat_q;
        fwd_d   = 1'b0;
        fout_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d = bus.max_cntr;
                    if (!bus.acc_keep) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                    state_d = (bus.max_cntr == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!a_empty && !b_empty && !bus.ais && !bus.bis) begin
                    pop     = 1'b1;
                    acc_d   = sum[ACCW-1:0];
                    ovf_d   = ovf_q | (sum[ACCW] ^ sum[ACCW-1]);
                    a_out_d = a_head;
                    b_out_d = b_head;
                    fwd_d   = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                s_out_d = clip_hi ? S_MAX[DW-1:0] : (clip_lo ? S_MIN[DW-1:0] : scaled[DW-1:0]);
                sat_d   = ovf_q | clip_hi | clip_lo;
                fout_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            s_out_q      <= '0;
            sat_q        <= 1'b0;
            fwd_q        <= 1'b0;
            fout_q       <= 1'b0;
            start_next_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            s_out_q      <= s_out_d;
            sat_q        <= sat_d;
            fwd_q        <= fwd_d;
            fout_q       <= fout_d;
            start_next_q <= bus.start;
        end
    end

    assign bus.aff        = a_full;
    assign bus.bff        = b_full;
    assign bus.a_out      = a_out_q;
    assign bus.b_out      = b_out_q;
    assign bus.awe_next   = fwd_q;
    assign bus.bwe_next   = fwd_q;
    assign bus.start_next = start_next_q;
    assign bus.se         = (state_q != ST_IDLE);
    assign bus.fout       = fout_q;
    assign bus.sat        = sat_q;
    assign bus.s_out      = s_out_q;
endmodule

// File: tb/tb_pe_gen.sv
// Directed bench for pe_gen: two tiles (FRAC=0 and FRAC=8) share one stimulus stream and
// are compared every cycle against a queue/arithmetic model, plus hand-computed results.
module tb_pe_gen;
    localparam int     FD       = 4;
    localparam longint ACC_SPAN = longint'(1) <<< 40;
    localparam longint ACC_MAX  = (longint'(1) <<< 39) - 1;
    localparam longint ACC_MIN  = -(longint'(1) <<< 39);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_gen_if #(.DW(16), .CW(8)) ifc0 ();
    pe_gen_if #(.DW(16), .CW(8)) ifc8 ();

    assign ifc8.start    = ifc0.start;
    assign ifc8.max_cntr = ifc0.max_cntr;
    assign ifc8.acc_keep = ifc0.acc_keep;
    assign ifc8.a_in     = ifc0.a_in;
    assign ifc8.awe      = ifc0.awe;
    assign ifc8.b_in     = ifc0.b_in;
    assign ifc8.bwe      = ifc0.bwe;
    assign ifc8.ais      = ifc0.ais;
    assign ifc8.bis      = ifc0.bis;

    pe_gen #(.DW(16), .ACCW(40), .FDEPTH(FD), .CW(8), .FRAC(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    pe_gen #(.DW(16), .ACCW(40), .FDEPTH(FD), .CW(8), .FRAC(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operand queues, exact accumulator with 40-bit wrap, and the expected outputs.
    int     qa[$], qb[$];
    bit     m_busy, m_fin, m_ovf;
    int     m_cnt;
    longint m_acc;
    longint e_aout, e_bout, e_s0, e_s8;
    bit     e_fwd, e_fout, e_stn, e_sat0, e_sat8;
    int     fwd_a[$];

    function automatic void result(input int frac, output longint s, output bit sat);
        longint r = m_acc >>> frac;
        bit clip = (r > 32767) || (r < -32768);
        s   = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
        sat = m_ovf | clip;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit a_full_pre, b_full_pre, pop;
        longint t;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            m_busy = 0; m_fin = 0; m_ovf = 0; m_cnt = 0; m_acc = 0;
            e_aout = 0; e_bout = 0; e_s0 = 0; e_s8 = 0;
            e_fwd = 0; e_fout = 0; e_stn = 0; e_sat0 = 0; e_sat8 = 0;
        end else begin
            a_full_pre = (qa.size() == FD);
            b_full_pre = (qb.size() == FD);
            pop = m_busy && !m_fin && qa.size() > 0 && qb.size() > 0 && !ifc0.ais && !ifc0.bis;
            e_fwd  = 0;
            e_fout = 0;
            e_stn  = ifc0.start;
            if (m_fin) begin
                result(0, e_s0, e_sat0);
                result(8, e_s8, e_sat8);
                e_fout = 1; m_fin = 0; m_busy = 0;
            end else if (pop) begin
                e_aout = qa.pop_front();
                e_bout = qb.pop_front();
                t = m_acc + e_aout * e_bout;
                if (t > ACC_MAX) begin t -= ACC_SPAN; m_ovf = 1; end
                else if (t < ACC_MIN) begin t += ACC_SPAN; m_ovf = 1; end
                m_acc = t;
                e_fwd = 1;
                m_cnt--;
                if (m_cnt == 0) m_fin = 1;
            end else if (!m_busy && ifc0.start) begin
                m_cnt = int'(ifc0.max_cntr);
                if (!ifc0.acc_keep) begin m_acc = 0; m_ovf = 0; end
                m_busy = 1;
                m_fin  = (m_cnt == 0);
            end
            if (ifc0.awe && (!a_full_pre || pop)) qa.push_back(int'(ifc0.a_in));
            if (ifc0.bwe && (!b_full_pre || pop)) qb.push_back(int'(ifc0.b_in));
        end
    end

    always @(negedge clk) begin
        check("aff",        ifc0.aff,        qa.size() == FD);
        check("bff",        ifc0.bff,        qb.size() == FD);
        check("se",         ifc0.se,         m_busy);
        check("start_next", ifc0.start_next, e_stn);
        check("awe_next",   ifc0.awe_next,   e_fwd);
        check("bwe_next",   ifc0.bwe_next,   e_fwd);
        check("a_out",      ifc0.a_out,      e_aout);
        check("b_out",      ifc0.b_out,      e_bout);
        check("fout",       ifc0.fout,       e_fout);
        check("s_out_f0",   ifc0.s_out,      e_s0);
        check("sat_f0",     ifc0.sat,        e_sat0);
        check("fout_f8",    ifc8.fout,       e_fout);
        check("s_out_f8",   ifc8.s_out,      e_s8);
        check("sat_f8",     ifc8.sat,        e_sat8);
        if (ifc0.awe_next) fwd_a.push_back(int'(ifc0.a_out));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b, input bit wa, input bit wb);
        ifc0.a_in = 16'(a); ifc0.b_in = 16'(b);
        ifc0.awe = wa; ifc0.bwe = wb;
        tick();
        ifc0.awe = 0; ifc0.bwe = 0;
    endtask

    task automatic start_run(input int cnt, input bit keep);
        ifc0.start = 1; ifc0.max_cntr = 8'(cnt); ifc0.acc_keep = keep;
        tick();
        ifc0.start = 0; ifc0.acc_keep = 0;
    endtask

    // Returns the number of edges after the accepting edge until fout is seen.
    task automatic wait_fout(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifc0.fout && n < 40);
        check("fout_seen", ifc0.fout, 1);
    endtask

    task automatic expect_res(input string tag, input longint s0, input bit sat0, input longint s8, input bit sat8);
        check({tag, "_s0"},      ifc0.s_out, s0);
        check({tag, "_sat0"},    ifc0.sat,   sat0);
        check({tag, "_s8"},      ifc8.s_out, s8);
        check({tag, "_sat8"},    ifc8.sat,   sat8);
        check({tag, "_model_s0"}, e_s0,      s0);
        check({tag, "_model_s8"}, e_s8,      s8);
    endtask

    task automatic push_s1();
        push(100, 200, 1, 1);
        push(300, 100, 1, 1);
        push(255, 256, 1, 1);
        push(100, 100, 1, 1);
    endtask

    initial begin
        int n;
        int exp_fwd[4] = '{100, 300, 255, 100};
        ifc0.start = 0; ifc0.max_cntr = 0; ifc0.acc_keep = 0;
        ifc0.a_in = 0; ifc0.awe = 0; ifc0.b_in = 0; ifc0.bwe = 0;
        ifc0.ais = 0; ifc0.bis = 0;
        tick(); tick();
        check("rst_se", ifc0.se, 0);
        check("rst_s_out", ifc0.s_out, 0);
        check("rst_aff", ifc0.aff, 0);
        rst_n = 1;
        tick();

        // Overflowing positive sum, forwarding order and base latency.
        push_s1();
        fwd_a.delete();
        start_run(4, 0);
        wait_fout(n);
        check("s1_latency", n, 5);
        expect_res("s1", 32767, 1, 489, 0);
        check("s1_fwd_count", fwd_a.size(), 4);
        for (int i = 0; i < 4 && i < fwd_a.size(); i++) check("s1_fwd_a", fwd_a[i], exp_fwd[i]);
        tick();

        // Negative clip, with one B-side stall cycle.
        push(-200, 300, 1, 1);
        push(-200, 300, 1, 1);
        ifc0.bis = 1;
        start_run(2, 0);
        tick();
        ifc0.bis = 0;
        wait_fout(n);
        expect_res("neg", -32768, 1, -469, 0);
        tick();

        // Operands arriving after start.
        start_run(2, 0);
        push(3, -4, 1, 1);
        push(5, 6, 1, 1);
        wait_fout(n);
        expect_res("small", 18, 0, 0, 0);
        tick();

        // Preload A past full; then write into the full FIFO on the first pop.
        for (int i = 1; i <= 5; i++) begin
            push(i, 0, 1, 0);
            if (i == 3) check("pre_aff3", ifc0.aff, 0);
            if (i == 4) check("pre_aff4", ifc0.aff, 1);
        end
        check("pre_aff5", ifc0.aff, 1);
        for (int i = 1; i <= 4; i++) push(0, 10 * i, 0, 1);
        check("pre_bff", ifc0.bff, 1);
        fwd_a.delete();
        start_run(4, 0);
        push(7, 0, 1, 0);
        wait_fout(n);
        expect_res("pre", 300, 0, 1, 0);
        check("pre_fwd_count", fwd_a.size(), 4);
        for (int i = 0; i < 4 && i < fwd_a.size(); i++) check("pre_fwd_a", fwd_a[i], i + 1);
        check("pre_aff_after", ifc0.aff, 0);
        push(0, 8, 0, 1);
        start_run(1, 0);
        wait_fout(n);
        expect_res("leftover", 56, 0, 0, 0);
        tick();

        // A-side stall for three RUN cycles delays the result by three cycles.
        push_s1();
        ifc0.ais = 1;
        start_run(4, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_awe_next", ifc0.awe_next, 0);
        end
        ifc0.ais = 0;
        wait_fout(n);
        check("stall_latency", 3 + n, 8);
        expect_res("stall", 32767, 1, 489, 0);
        tick();

        // Chaining with acc_keep, back-to-back start in the fout cycle, zero-length run.
        push(2, 3, 1, 1);
        start_run(1, 0);
        wait_fout(n);
        expect_res("chain1", 6, 0, 0, 0);
        start_run(1, 1);
        push(4, 5, 1, 1);
        wait_fout(n);
        expect_res("chain2", 26, 0, 0, 0);
        start_run(0, 1);
        wait_fout(n);
        check("zero_latency", n, 1);
        expect_res("zero", 26, 0, 0, 0);
        tick();

        // Reset in the middle of a run.
        push(1, 1, 1, 1);
        start_run(4, 0);
        tick(); tick();
        check("mid_se_busy", ifc0.se, 1);
        rst_n = 0;
        #1;
        check("mid_rst_se", ifc0.se, 0);
        check("mid_rst_s_out", ifc0.s_out, 0);
        check("mid_rst_a_out", ifc0.a_out, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_fout", ifc0.fout, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
